adc_frame_scheduler: RTL and testbench

- Sequences one measurement frame end to end: arms ADC capture into the sample FIFO, counts DATA_NUM samples, then drains the FIFO to the UART transmitter.
- Each frame is wrapped in a header, a length field and a checksum.
- Sits between the host trigger logic, the ADC sample FIFO (write/read request side) and the UART byte transmitter, and replaces ad-hoc read-clock pulse generation with a proper byte handshake.

---
 rtl/adc_frame_scheduler.sv | 161 ++++++++++++++++
 tb/tb_adc_frame_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_scheduler.sv
// ADC frame scheduler: captures DATA_NUM samples into the FIFO, then streams
// header, length, payload and checksum to the UART with a valid/ready handshake.
module adc_frame_scheduler #(
    parameter int          DATA_NUM = 405,
    parameter logic [7:0]  HDR0     = 8'hA5,
    parameter logic [7:0]  HDR1     = 8'h5A,
    parameter logic [19:0] TIMEOUT  = 20'd500000
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_enable,
    input  logic       in_trig_req,
    input  logic       in_adc_valid,
    output logic       out_fifo_wrreq,
    output logic       out_fifo_rdreq,
    input  logic [7:0] in_fifo_q,
    input  logic       in_fifo_empty,
    output logic [7:0] out_tx_data,
    output logic       out_tx_valid,
    input  logic       in_tx_ready,
    output logic       out_busy,
    output logic       out_frame_done,
    output logic       out_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_CAPTURE, S_HDR0, S_HDR1, S_LEN_H, S_LEN_L,
        S_READ, S_WAIT_Q, S_PAYLOAD, S_CHK, S_ERR
    } state_t;

    localparam logic [15:0] LEN  = 16'(DATA_NUM);
    localparam logic [9:0]  LAST = LEN[9:0];

    state_t      state, state_nx;
    logic [9:0]  smp_cnt, byte_cnt;
    logic [19:0] idle_cnt;
    logic [7:0]  chk_sum, q_reg;
    logic        done_q, err_q;
    logic        accept, trig_ok;

    always_comb begin
        state_nx       = state;
        out_fifo_wrreq = 1'b0;
        out_fifo_rdreq = 1'b0;
        out_tx_valid   = 1'b0;
        out_tx_data    = 8'h00;
        trig_ok        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (in_trig_req && in_enable) begin
                    trig_ok  = 1'b1;
                    state_nx = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                out_fifo_wrreq = in_adc_valid;
                // a final strobe outranks a timeout in the same cycle
                if (in_adc_valid) begin
                    if (smp_cnt + 10'd1 == LAST) state_nx = S_HDR0;
                end else if (idle_cnt >= TIMEOUT) begin
                    state_nx = S_ERR;
                end
            end
            S_HDR0: begin
                out_tx_valid = 1'b1;
                out_tx_data  = HDR0;
                if (in_tx_ready) state_nx = S_HDR1;
            end
            S_HDR1: begin
                out_tx_valid = 1'b1;
                out_tx_data  = HDR1;
                if (in_tx_ready) state_nx = S_LEN_H;
            end
            S_LEN_H: begin
                out_tx_valid = 1'b1;
                out_tx_data  = LEN[15:8];
                if (in_tx_ready) state_nx = S_LEN_L;
            end
            S_LEN_L: begin
                out_tx_valid = 1'b1;
                out_tx_data  = LEN[7:0];
                if (in_tx_ready) state_nx = S_READ;
            end
            S_READ: begin
                if (!in_fifo_empty) begin
                    out_fifo_rdreq = 1'b1;
                    state_nx       = S_WAIT_Q;
                end else begin
                    state_nx = S_ERR;
                end
            end
            S_WAIT_Q: state_nx = S_PAYLOAD;
            S_PAYLOAD: begin
                out_tx_valid = 1'b1;
                out_tx_data  = q_reg;
                if (in_tx_ready)
                    state_nx = (byte_cnt + 10'd1 == LAST) ? S_CHK : S_READ;
            end
            S_CHK: begin
                out_tx_valid = 1'b1;
                out_tx_data  = chk_sum;
                if (in_tx_ready) state_nx = S_IDLE;
            end
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        // disable kills every request at once and never flags an error
        if (state != S_IDLE && !in_enable) begin
            state_nx       = S_IDLE;
            out_fifo_wrreq = 1'b0;
            out_fifo_rdreq = 1'b0;
            out_tx_valid   = 1'b0;
        end
        accept = out_tx_valid && in_tx_ready;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state    <= S_IDLE;
            smp_cnt  <= '0;
            byte_cnt <= '0;
            idle_cnt <= '0;
            chk_sum  <= '0;
            q_reg    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= accept && state == S_CHK;
            if (trig_ok) begin
                err_q    <= 1'b0;
                smp_cnt  <= '0;
                byte_cnt <= '0;
                idle_cnt <= '0;
                chk_sum  <= '0;
            end
            if (state == S_CAPTURE) begin
                if (out_fifo_wrreq) begin
                    smp_cnt  <= smp_cnt + 10'd1;
                    idle_cnt <= '0;
                end else if (idle_cnt != '1) begin
                    idle_cnt <= idle_cnt + 20'd1;
                end
            end
            if (accept && (state == S_LEN_H || state == S_LEN_L ||
                           state == S_PAYLOAD))
                chk_sum <= chk_sum + out_tx_data;
            if (accept && state == S_PAYLOAD)
                byte_cnt <= byte_cnt + 10'd1;
            if (state == S_WAIT_Q)
                q_reg <= in_fifo_q;
            if (state_nx == S_ERR)
                err_q <= 1'b1;
        end
    end

    assign out_busy       = state != S_IDLE;
    assign out_frame_done = done_q;
    assign out_err        = err_q;

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Bench for adc_frame_scheduler: FIFO model, byte monitor and a frame
// reference model built from header/length/payload/checksum rules.
`timescale 1ns/1ps
module tb_adc_frame_scheduler;

    localparam int          N  = 4;
    localparam logic [19:0] TO = 20'd1000;
    localparam logic [7:0]  H0 = 8'hA5;
    localparam logic [7:0]  H1 = 8'h5A;

    logic       clk = 1'b0;
    logic       rst, en, trig, adc_valid, tx_ready;
    logic       wrreq, rdreq, fempty, tx_valid, busy, done, err;
    logic [7:0] fifo_q = 8'h00;
    logic [7:0] tx_data, adc_data;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int cyc    = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int rdy_mode = 0;
    bit force_empty = 1'b0;
    bit flush = 1'b0;
    bit hold = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic [7:0] samp[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    logic [7:0] mem [0:63];
    logic [5:0] wp = 6'd0;
    logic [5:0] rp = 6'd0;

    always #5 clk = ~clk;

    adc_frame_scheduler #(
        .DATA_NUM(N), .HDR0(H0), .HDR1(H1), .TIMEOUT(TO)
    ) dut (
        .in_clk(clk), .in_rst(rst), .in_enable(en),
        .in_trig_req(trig), .in_adc_valid(adc_valid),
        .out_fifo_wrreq(wrreq), .out_fifo_rdreq(rdreq),
        .in_fifo_q(fifo_q), .in_fifo_empty(fempty),
        .out_tx_data(tx_data), .out_tx_valid(tx_valid),
        .in_tx_ready(tx_ready), .out_busy(busy),
        .out_frame_done(done), .out_err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        total++;
        assert (obs === want) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // FIFO: data is registered, so q is valid the cycle after rdreq
    assign fempty = (wp == rp) || force_empty;
    always @(posedge clk) begin
        if (flush) begin
            rp <= wp;
        end else begin
            if (wrreq) begin
                mem[wp] <= adc_data;
                wp <= wp + 6'd1;
            end
            if (rdreq) begin
                fifo_q <= mem[rp];
                rp <= rp + 6'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (wrreq) wr_cnt++;
        if (rdreq) begin
            rd_cnt++;
            chk("rd_while_empty", fempty, 0);
        end
        if (tx_valid && tx_ready) got.push_back(tx_data);
        if (hold && en && !rst)
            chk("tx_hold", {tx_valid, tx_data}, {1'b1, hold_data});
        hold = tx_valid && !tx_ready;
        hold_data = tx_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (rdy_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = (cyc % 3 == 0);
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic do_frame(input bit fixed, input int nsamp, input bit trig_mid);
        logic [7:0] v;
        samp.delete();
        got.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("err_cleared", err, 0);
        chk("busy_capture", busy, 1);
        for (int i = 0; i < nsamp; i++) begin
            int gap;
            gap = $urandom_range(trig_mid ? 1 : 0, 3);
            for (int g = 0; g < gap; g++) begin
                trig = trig_mid && i == 1 && g == 0;
                tick();
                trig = 1'b0;
            end
            v = fixed ? 8'(16 * (i + 1)) : 8'($urandom);
            adc_data = v;
            adc_valid = 1'b1;
            samp.push_back(v);
            tick();
            adc_valid = 1'b0;
        end
        if (nsamp == N) begin
            chk("wr_count", wr_cnt, N);
            chk("first_valid", tx_valid, 1);
            chk("first_byte", tx_data, H0);
        end
    endtask

    task automatic finish_frame(input bit trig_mid);
        logic [7:0] sum;
        int lim;
        for (int k = 0; k < 300 && !done; k++) begin
            trig = trig_mid && k == 4;
            tick();
            trig = 1'b0;
        end
        chk("frame_done", done, 1);
        chk("busy_after", busy, 0);
        exp_q.delete();
        exp_q.push_back(H0);
        exp_q.push_back(H1);
        exp_q.push_back(8'(N >> 8));
        exp_q.push_back(8'(N));
        sum = 8'(N >> 8) + 8'(N);
        foreach (samp[i]) begin
            exp_q.push_back(samp[i]);
            sum = sum + samp[i];
        end
        exp_q.push_back(sum);
        chk("n_bytes", got.size(), exp_q.size());
        lim = got.size() < exp_q.size() ? got.size() : exp_q.size();
        for (int i = 0; i < lim; i++)
            chk($sformatf("byte%0d", i), got[i], exp_q[i]);
        chk("rd_count", rd_cnt, N);
        tick();
        chk("done_pulse", done, 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, tx_valid, 0);
        chk({tag, "_wrreq"}, wrreq, 0);
        chk({tag, "_rdreq"}, rdreq, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle;
        rst = 1'b1;
        en = 1'b1;
        trig = 1'b0;
        adc_valid = 1'b0;
        adc_data = 8'h00;
        tx_ready = 1'b1;
        repeat (3) tick();
        chk_quiet("reset");
        chk("reset_data", tx_data, 0);
        rst = 1'b0;
        tick();

        do_frame(1'b1, N, 1'b0);
        finish_frame(1'b0);

        rdy_mode = 1;
        do_frame(1'b1, N, 1'b1);
        finish_frame(1'b1);

        rdy_mode = 2;
        repeat (3) begin
            do_frame(1'b0, N, 1'b0);
            finish_frame(1'b0);
        end

        rdy_mode = 0;
        do_frame(1'b0, 2, 1'b0);
        idle = 0;
        while (!err && idle < int'(TO) + 50) begin
            tick();
            idle++;
        end
        chk("timeout_err", err, 1);
        chk("timeout_window", idle >= int'(TO) - 2 && idle <= int'(TO) + 5, 1);
        tick();
        chk("timeout_busy", busy, 0);
        chk("timeout_no_tx", got.size(), 0);
        do_flush();
        do_frame(1'b0, N, 1'b0);
        finish_frame(1'b0);

        do_frame(1'b0, N, 1'b0);
        for (int k = 0; k < 100 && got.size() != 6; k++) tick();
        force_empty = 1'b1;
        for (int k = 0; k < 10 && !err; k++) tick();
        chk("underflow_err", err, 1);
        chk("underflow_rd", rd_cnt, 2);
        tick();
        chk("underflow_busy", busy, 0);
        force_empty = 1'b0;
        do_flush();

        do_frame(1'b0, N, 1'b0);
        for (int k = 0; k < 100 && !(got.size() == 6 && tx_valid); k++) tick();
        chk("abort_pre_valid", tx_valid, 1);
        en = 1'b0;
        #1;
        chk("abort_valid", tx_valid, 0);
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_err", err, 0);
        chk("abort_bytes", got.size(), 6);
        en = 1'b1;
        do_flush();

        do_frame(1'b0, 2, 1'b0);
        rst = 1'b1;
        adc_valid = 1'b1;
        tick();
        chk_quiet("midrst");
        rst = 1'b0;
        adc_valid = 1'b0;
        do_flush();
        do_frame(1'b0, N, 1'b0);
        finish_frame(1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
